// File: rtl/lock_matrix_arbiter.sv
// N-way least-recently-granted arbiter with lockable, time-bounded multi-cycle grants.
// Grant is registered 1 cycle after req; no backpressure, an owner is forcibly preempted after MAX_HOLD cycles.
module lock_matrix_arbiter #(
   parameter int NUM_REQUESTORS = 4,
   parameter int MAX_HOLD       = 8,
   parameter int ID_WIDTH       = $clog2(NUM_REQUESTORS)
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NUM_REQUESTORS-1:0]                req,
   input  logic [NUM_REQUESTORS-1:0]                lock,
   input  logic                                     prio_load,
   input  logic [NUM_REQUESTORS*NUM_REQUESTORS-1:0] prio_wdata,
   output logic [NUM_REQUESTORS-1:0]                grant,
   output logic [ID_WIDTH-1:0]                      grant_id,
   output logic                                     grant_valid,
   output logic                                     preempt
);

   localparam int N     = NUM_REQUESTORS;
   localparam int NPAIR = N * (N - 1) / 2;
   localparam int HC_W  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

   // Packed position of pair (i,j), i<j, in the upper-triangle store.
   function automatic int pidx(input int i, input int j);
      return i * N - (i * (i + 1)) / 2 + (j - i - 1);
   endfunction

   typedef enum logic {IDLE, HELD} state_t;

   state_t            state_q, state_d;
   logic [NPAIR-1:0]  m_q, m_d, m_upd, m_load;
   logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [N-1:0]      grant_d;
   logic [ID_WIDTH-1:0] grant_id_d;
   logic              preempt_d;

   logic [N-1:0][N-1:0] beats;
   logic [N-1:0]      win_vec;
   logic [ID_WIDTH-1:0] win_id;
   logic              win_any;
   logic              owner_req, owner_lock;
   logic              hold_ok, expired, rearb;
   logic              unused_wdata;

   assign unused_wdata = ^prio_wdata;

   // Full antisymmetric view of the stored triangle; i wins if it beats every other requestor.
   for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_col
         if (gi < gj) begin : g_up
            assign beats[gi][gj] = m_q[pidx(gi, gj)];
         end else if (gi > gj) begin : g_lo
            assign beats[gi][gj] = ~m_q[pidx(gj, gi)];
         end else begin : g_diag
            assign beats[gi][gj] = 1'b1;
         end
      end
      assign win_vec[gi] = req[gi] & (&(beats[gi] | ~req));
   end

   always_comb begin
      win_id = '0;
      for (int i = 0; i < N; i++) begin
         if (win_vec[i]) win_id = ID_WIDTH'(i);
      end
   end

   assign win_any = |req;

   // The new winner drops below every other requestor.
   for (genvar pi = 0; pi < N; pi++) begin : g_pi
      for (genvar pj = pi + 1; pj < N; pj++) begin : g_pj
         assign m_load[pidx(pi, pj)] = prio_wdata[pi * N + pj];
         assign m_upd[pidx(pi, pj)]  = (win_id == ID_WIDTH'(pi)) ? 1'b0 :
                                       (win_id == ID_WIDTH'(pj)) ? 1'b1 :
                                       m_q[pidx(pi, pj)];
      end
   end

   assign owner_req  = req[grant_id];
   assign owner_lock = lock[grant_id];
   assign hold_ok    = (state_q == HELD) && owner_req && owner_lock && (hold_cnt_q < HOLD_LAST);
   assign expired    = (state_q == HELD) && owner_req && owner_lock && (hold_cnt_q == HOLD_LAST);

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      grant_d    = grant;
      grant_id_d = grant_id;
      preempt_d  = 1'b0;
      rearb      = 1'b0;
      if (hold_ok) begin
         hold_cnt_d = hold_cnt_q + HC_W'(1);
      end else begin
         rearb      = 1'b1;
         hold_cnt_d = '0;
         if (win_any) begin
            grant_d    = win_vec;
            grant_id_d = win_id;
            state_d    = HELD;
            preempt_d  = expired && (win_id != grant_id);
         end else begin
            grant_d    = '0;
            grant_id_d = '0;
            state_d    = IDLE;
         end
      end
   end

   // A priority load takes precedence over the grant-event update.
   always_comb begin
      m_d = m_q;
      if (prio_load) begin
         m_d = m_load;
      end else if (rearb && win_any) begin
         m_d = m_upd;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         m_q        <= '1;
         hold_cnt_q <= '0;
         grant      <= '0;
         grant_id   <= '0;
         preempt    <= 1'b0;
      end else begin
         state_q    <= state_d;
         m_q        <= m_d;
         hold_cnt_q <= hold_cnt_d;
         grant      <= grant_d;
         grant_id   <= grant_id_d;
         preempt    <= preempt_d;
      end
   end

   assign grant_valid = |grant;

   a_grant_onehot : assert property (@(posedge clk) $onehot0(grant));
   a_hold_bound   : assert property (@(posedge clk) hold_cnt_q <= HOLD_LAST);

endmodule

// File: tb/tb_lock_matrix_arbiter.sv
// Bench for lock_matrix_arbiter with N=4, MAX_HOLD=4.
module tb_lock_matrix_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  lock;
   logic        prio_load;
   logic [15:0] prio_wdata;
   logic [3:0]  grant;
   logic [1:0]  grant_id;
   logic        grant_valid;
   logic        preempt;

   always #5 clk = ~clk;

   lock_matrix_arbiter #(
      .NUM_REQUESTORS(4),
      .MAX_HOLD      (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .lock       (lock),
      .prio_load  (prio_load),
      .prio_wdata (prio_wdata),
      .grant      (grant),
      .grant_id   (grant_id),
      .grant_valid(grant_valid),
      .preempt    (preempt)
   );

   typedef struct {
      logic        rst_n;
      logic [3:0]  req;
      logic [3:0]  lock;
      logic        pl;
      logic [15:0] pw;
      logic [3:0]  g;
      logic [1:0]  id;
      logic        pre;
   } vec_t;

   typedef struct {
      logic [3:0] g;
      logic [1:0] id;
      logic       pre;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;
   int   stepn  = 0;

   task automatic add(input logic r, input logic [3:0] q, input logic [3:0] l,
                      input logic p, input logic [15:0] w,
                      input logic [3:0] g, input logic [1:0] id, input logic pre);
      vec_t v;
      v.rst_n = r; v.req = q; v.lock = l; v.pl = p; v.pw = w;
      v.g = g; v.id = id; v.pre = pre;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s step %0d: got %0h, expected %0h", name, stepn, act, exp);
   endtask

   task automatic step(input logic r, input logic [3:0] q, input logic [3:0] l,
                       input logic p, input logic [15:0] w,
                       input logic [3:0] g, input logic [1:0] id, input logic pre);
      exp_t e;
      rst = r; req = q; lock = l; prio_load = p; prio_wdata = w;
      e.g = g; e.id = id; e.pre = pre;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("grant",       grant,                e.g);
      chk("grant_id",    {2'b00, grant_id},    {2'b00, e.id});
      chk("grant_valid", {3'b000, grant_valid}, {3'b000, |e.g});
      chk("preempt",     {3'b000, preempt},    {3'b000, e.pre});
      stepn++;
   endtask

   initial begin
      logic [3:0] eg;
      logic [1:0] eid;
      logic       epre;

      rst = 1'b0; req = '0; lock = '0; prio_load = 1'b0; prio_wdata = '0;

      // Reset state, reset dominating req/lock, then LRU rotation without lock.
      add(0, 4'b0000, 4'b0000, 0, 16'h0, 4'b0000, 2'd0, 0);
      add(0, 4'b1111, 4'b1111, 0, 16'h0, 4'b0000, 2'd0, 0);
      add(1, 4'b1111, 4'b0000, 0, 16'h0, 4'b0001, 2'd0, 0);
      add(1, 4'b1111, 4'b0000, 0, 16'h0, 4'b0010, 2'd1, 0);
      add(1, 4'b1111, 4'b0000, 0, 16'h0, 4'b0100, 2'd2, 0);
      add(1, 4'b1111, 4'b0000, 0, 16'h0, 4'b1000, 2'd3, 0);
      add(1, 4'b1111, 4'b0000, 0, 16'h0, 4'b0001, 2'd0, 0);
      add(1, 4'b0000, 4'b0000, 0, 16'h0, 4'b0000, 2'd0, 0);
      // Lock handover with forced preemption after MAX_HOLD cycles.
      add(0, 4'b0000, 4'b0000, 0, 16'h0, 4'b0000, 2'd0, 0);
      add(1, 4'b0100, 4'b0100, 0, 16'h0, 4'b0100, 2'd2, 0);
      add(1, 4'b1111, 4'b0100, 0, 16'h0, 4'b0100, 2'd2, 0);
      add(1, 4'b1111, 4'b0100, 0, 16'h0, 4'b0100, 2'd2, 0);
      add(1, 4'b1111, 4'b0100, 0, 16'h0, 4'b0100, 2'd2, 0);
      add(1, 4'b1111, 4'b0100, 0, 16'h0, 4'b0001, 2'd0, 1);
      add(1, 4'b1111, 4'b0100, 0, 16'h0, 4'b0010, 2'd1, 0);
      // Priority load: requestor 3 beats everyone, then drops to lowest after winning.
      add(0, 4'b0000, 4'b0000, 0, 16'h0,    4'b0000, 2'd0, 0);
      add(1, 4'b0000, 4'b0000, 1, 16'hF777, 4'b0000, 2'd0, 0);
      add(1, 4'b1001, 4'b0000, 0, 16'h0,    4'b1000, 2'd3, 0);
      add(1, 4'b1001, 4'b0000, 0, 16'h0,    4'b0001, 2'd0, 0);
      // Load on a grant edge wins over the LRU update; grant uses the old matrix.
      add(0, 4'b0000, 4'b0000, 0, 16'h0,    4'b0000, 2'd0, 0);
      add(1, 4'b1111, 4'b0000, 1, 16'hFFFF, 4'b0001, 2'd0, 0);
      add(1, 4'b1111, 4'b0000, 0, 16'h0,    4'b0001, 2'd0, 0);
      // Early release by dropping lock: immediate handover, no bubble.
      add(0, 4'b0000, 4'b0000, 0, 16'h0, 4'b0000, 2'd0, 0);
      add(1, 4'b0100, 4'b0100, 0, 16'h0, 4'b0100, 2'd2, 0);
      add(1, 4'b0101, 4'b0100, 0, 16'h0, 4'b0100, 2'd2, 0);
      add(1, 4'b0101, 4'b0000, 0, 16'h0, 4'b0001, 2'd0, 0);
      // Reset mid-hold restores default matrix.
      add(0, 4'b0000, 4'b0000, 0, 16'h0, 4'b0000, 2'd0, 0);
      add(1, 4'b0100, 4'b0100, 0, 16'h0, 4'b0100, 2'd2, 0);
      add(1, 4'b1111, 4'b0100, 0, 16'h0, 4'b0100, 2'd2, 0);
      add(0, 4'b1111, 4'b1111, 0, 16'h0, 4'b0000, 2'd0, 0);
      add(1, 4'b1010, 4'b0000, 0, 16'h0, 4'b0010, 2'd1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst_n, vecs[i].req, vecs[i].lock, vecs[i].pl, vecs[i].pw,
              vecs[i].g, vecs[i].id, vecs[i].pre);
      end

      // Lone locker: re-grant to itself on expiry, never a preempt pulse.
      step(0, 4'b0000, 4'b0000, 0, 16'h0, 4'b0000, 2'd0, 0);
      for (int k = 0; k < 12; k++) begin
         step(1, 4'b0010, 4'b0010, 0, 16'h0, 4'b0010, 2'd1, 0);
      end

      // Two lockers alternate every MAX_HOLD cycles with a preempt pulse at each switch.
      step(0, 4'b0000, 4'b0000, 0, 16'h0, 4'b0000, 2'd0, 0);
      for (int k = 0; k < 12; k++) begin
         eid  = ((k / 4) % 2 == 1) ? 2'd1 : 2'd0;
         eg   = (eid == 2'd1) ? 4'b0010 : 4'b0001;
         epre = (k > 0) && (k % 4 == 0);
         step(1, 4'b0011, 4'b0011, 0, 16'h0, eg, eid, epre);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
